// File: rtl/partial_sat_evaluator_pkg.sv
// Shared constants for the SAT clause evaluation datapath.
//   DEFAULT_VAR_PER_CLAUSE : default number of literal slots per clause
//   POLE_POS / POLE_NEG    : polarity encoding of a literal slot
//   idx_width / cnt_width  : width helpers for slot index and open-literal count
package sat_pkg;

    localparam int DEFAULT_VAR_PER_CLAUSE = 5;

    localparam logic POLE_POS = 1'b0;
    localparam logic POLE_NEG = 1'b1;

    // Slot index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/partial_sat_evaluator_if.sv
// Clause evaluation bus: one clause's literal vectors in, registered verdict out.
//   master : drives in_valid, unassign, clause_mask, val, clause_pole
//   slave  : drives out_valid, partial_sat, conflict, unit, unit_idx, unassigned_cnt
interface partial_sat_evaluator_if
    import sat_pkg::*;
#(
    parameter int VAR_PER_CLAUSE = DEFAULT_VAR_PER_CLAUSE
);
    localparam int IDX_W = idx_width(VAR_PER_CLAUSE);
    localparam int CNT_W = cnt_width(VAR_PER_CLAUSE);

    logic                      in_valid;
    logic [VAR_PER_CLAUSE-1:0] unassign;
    logic [VAR_PER_CLAUSE-1:0] clause_mask;
    logic [VAR_PER_CLAUSE-1:0] val;
    logic [VAR_PER_CLAUSE-1:0] clause_pole;

    logic                      out_valid;
    logic                      partial_sat;
    logic                      conflict;
    logic                      unit;
    logic [IDX_W-1:0]          unit_idx;
    logic [CNT_W-1:0]          unassigned_cnt;

    modport master (
        output in_valid, unassign, clause_mask, val, clause_pole,
        input  out_valid, partial_sat, conflict, unit, unit_idx, unassigned_cnt
    );

    modport slave (
        input  in_valid, unassign, clause_mask, val, clause_pole,
        output out_valid, partial_sat, conflict, unit, unit_idx, unassigned_cnt
    );

endinterface

// File: rtl/partial_sat_evaluator_popcount.sv
// Counts the open (masked, unassigned) literals of a clause and reports the
// lowest open slot index.
//   lit_open : per-slot open flags
//   cnt      : number of set bits in lit_open
//   low_idx  : index of the lowest set bit (0 when none is set)
module clause_popcount_encoder #(
    parameter int N     = 5,
    parameter int IDX_W = 3,
    parameter int CNT_W = 3
) (
    input  logic [N-1:0]     lit_open,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] low_idx
);

    logic found_s;

    // Single pass: accumulate the count and latch the first open slot seen.
    always_comb begin
        cnt     = {CNT_W{1'b0}};
        low_idx = {IDX_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lit_open[i]) begin
                cnt = cnt + CNT_W'(1);
                if (!found_s) begin
                    low_idx = IDX_W'(i);
                    found_s = 1'b1;
                end else begin
                    found_s = 1'b1;
                end
            end else begin
                cnt = cnt;
            end
        end
    end

endmodule

// File: rtl/partial_sat_evaluator.sv
// Per-clause literal evaluator: decides whether a clause is already satisfied,
// in conflict, or unit, one cycle after a valid strobe.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears every output
//   bus     : slave side of the clause evaluation bus (inputs qualified by
//             in_valid; results registered and held while in_valid is low)
module partial_sat_evaluator
    import sat_pkg::*;
#(
    parameter int VAR_PER_CLAUSE = DEFAULT_VAR_PER_CLAUSE
) (
    input  logic                    clock,
    input  logic                    reset_n,
    partial_sat_evaluator_if.slave  bus
);

    localparam int IDX_W = idx_width(VAR_PER_CLAUSE);
    localparam int CNT_W = cnt_width(VAR_PER_CLAUSE);

    logic [VAR_PER_CLAUSE-1:0] lit_true_s;
    logic [VAR_PER_CLAUSE-1:0] lit_open_s;
    logic [CNT_W-1:0]          cnt_s;
    logic [IDX_W-1:0]          enc_idx_s;
    logic                      sat_s;
    logic                      conf_s;
    logic                      unit_s;
    logic [IDX_W-1:0]          idx_s;

    logic                      out_valid_r;
    logic                      partial_sat_r;
    logic                      conflict_r;
    logic                      unit_r;
    logic [IDX_W-1:0]          unit_idx_r;
    logic [CNT_W-1:0]          cnt_r;

    // Evaluate every slot; unmasked slots are neither true nor open, and val is
    // only consulted for assigned variables.
    always_comb begin
        lit_true_s = {VAR_PER_CLAUSE{1'b0}};
        lit_open_s = {VAR_PER_CLAUSE{1'b0}};
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            lit_open_s[i] = bus.clause_mask[i] & bus.unassign[i];
            if (bus.clause_mask[i] && !bus.unassign[i]) begin
                lit_true_s[i] = (bus.clause_pole[i] == POLE_NEG) ? ~bus.val[i] : bus.val[i];
            end else begin
                lit_true_s[i] = 1'b0;
            end
        end
    end

    clause_popcount_encoder #(
        .N     (VAR_PER_CLAUSE),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .lit_open (lit_open_s),
        .cnt      (cnt_s),
        .low_idx  (enc_idx_s)
    );

    // Clause verdict; satisfaction dominates, so the three flags stay exclusive.
    always_comb begin
        sat_s  = |lit_true_s;
        conf_s = (|bus.clause_mask) & ~sat_s & (cnt_s == CNT_W'(0));
        unit_s = ~sat_s & (cnt_s == CNT_W'(1));
        if (unit_s) begin
            idx_s = enc_idx_s;
        end else begin
            idx_s = IDX_W'(0);
        end
    end

    // Result registers load on a valid strobe and hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r   <= 1'b0;
            partial_sat_r <= 1'b0;
            conflict_r    <= 1'b0;
            unit_r        <= 1'b0;
            unit_idx_r    <= IDX_W'(0);
            cnt_r         <= CNT_W'(0);
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                partial_sat_r <= sat_s;
                conflict_r    <= conf_s;
                unit_r        <= unit_s;
                unit_idx_r    <= idx_s;
                cnt_r         <= cnt_s;
            end else begin
                partial_sat_r <= partial_sat_r;
                conflict_r    <= conflict_r;
                unit_r        <= unit_r;
                unit_idx_r    <= unit_idx_r;
                cnt_r         <= cnt_r;
            end
        end
    end

    assign bus.out_valid      = out_valid_r;
    assign bus.partial_sat    = partial_sat_r;
    assign bus.conflict       = conflict_r;
    assign bus.unit           = unit_r;
    assign bus.unit_idx       = unit_idx_r;
    assign bus.unassigned_cnt = cnt_r;

endmodule

// File: tb/tb_partial_sat_evaluator.sv
// Scoreboard bench for partial_sat_evaluator: directed vectors plus random
// traffic, checked against a slot-by-slot reference model of the clause rules.
module tb_partial_sat_evaluator;

    localparam int N = 5;

    typedef struct {
        int sat;
        int conf;
        int unit;
        int idx;
        int cnt;
    } exp_t;

    logic clock;
    logic reset_n;

    partial_sat_evaluator_if #(.VAR_PER_CLAUSE(N)) bus ();

    partial_sat_evaluator #(.VAR_PER_CLAUSE(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t held;
    bit   mon_en        = 1'b0;
    bit   last_in_valid = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the literals, evaluate each from its polarity, and
    // classify the clause from the number of true and open literals.
    function automatic exp_t model(input logic [N-1:0] u, input logic [N-1:0] m,
                                   input logic [N-1:0] v, input logic [N-1:0] p);
        exp_t e;
        int   n_true = 0;
        int   open_q[$];
        for (int i = 0; i < N; i++) begin
            if (!m[i]) continue;
            if (u[i]) open_q.push_back(i);
            else if ((p[i] ? !v[i] : v[i]) == 1'b1) n_true++;
        end
        e.sat  = (n_true > 0) ? 1 : 0;
        e.cnt  = open_q.size();
        e.conf = (m != 0 && e.sat == 0 && e.cnt == 0) ? 1 : 0;
        e.unit = (e.sat == 0 && e.cnt == 1) ? 1 : 0;
        e.idx  = (e.unit == 1) ? open_q[0] : 0;
        return e;
    endfunction

    task automatic drive(input bit v, input logic [N-1:0] u, input logic [N-1:0] m,
                         input logic [N-1:0] vl, input logic [N-1:0] p);
        @(posedge clock);
        #1;
        bus.in_valid    = v;
        bus.unassign    = u;
        bus.clause_mask = m;
        bus.val         = vl;
        bus.clause_pole = p;
        if (v) exp_q.push_back(model(u, m, vl, p));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_partial_sat"}, 32'(bus.partial_sat), 32'd0);
        check({tag, "_conflict"}, 32'(bus.conflict), 32'd0);
        check({tag, "_unit"}, 32'(bus.unit), 32'd0);
        check({tag, "_unit_idx"}, 32'(bus.unit_idx), 32'd0);
        check({tag, "_cnt"}, 32'(bus.unassigned_cnt), 32'd0);
    endtask

    // Monitor: out_valid must echo last cycle's in_valid; each valid output pops
    // one expectation, and results must hold steady between valid outputs.
    always @(negedge clock) begin
        if (mon_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(last_in_valid));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got output, expected none at %0t", $time);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check("partial_sat", 32'(bus.partial_sat), 32'(held.sat));
            check("conflict", 32'(bus.conflict), 32'(held.conf));
            check("unit", 32'(bus.unit), 32'(held.unit));
            check("unit_idx", 32'(bus.unit_idx), 32'(held.idx));
            check("unassigned_cnt", 32'(bus.unassigned_cnt), 32'(held.cnt));
            last_in_valid = bus.in_valid;
        end
    end

    initial begin
        held = '{sat: 0, conf: 0, unit: 0, idx: 0, cnt: 0};
        // Reset held with live, valid inputs: everything must stay zero.
        reset_n         = 1'b0;
        bus.in_valid    = 1'b1;
        bus.unassign    = 5'b00100;
        bus.clause_mask = 5'b11111;
        bus.val         = 5'b00011;
        bus.clause_pole = 5'b00111;
        #27;
        check_zero("reset");
        bus.in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        last_in_valid = 1'b0;
        mon_en        = 1'b1;

        // Directed vectors.
        drive(1'b1, 5'b11111, 5'b00000, 5'b10101, 5'b01010);
        drive(1'b1, 5'b01111, 5'b11100, 5'b00000, 5'b11100);
        drive(1'b1, 5'b01000, 5'b11100, 5'b01000, 5'b10100);
        drive(1'b1, 5'b00100, 5'b11111, 5'b00011, 5'b00111);
        drive(1'b1, 5'b00000, 5'b11111, 5'b00111, 5'b00111);
        drive(1'b1, 5'b11111, 5'b11111, 5'b00000, 5'b11100);
        drive(1'b1, 5'b00000, 5'b00000, 5'($urandom), 5'($urandom));
        drive(1'b1, 5'b11111, 5'b01000, 5'b00000, 5'b00000);
        drive(1'b1, 5'b10000, 5'b10000, 5'b11111, 5'b00000);
        // Hold and latency: in_valid 1,0,1 with changing inputs.
        drive(1'b1, 5'b00001, 5'b00011, 5'b00000, 5'b00000);
        drive(1'b0, 5'b00000, 5'b11111, 5'b11111, 5'b00000);
        drive(1'b1, 5'b00000, 5'b00110, 5'b00000, 5'b00000);
        drive(1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b00000);
        drive(1'b0, 5'b00000, 5'b00001, 5'b00001, 5'b00000);

        // Random traffic, with a bias toward full and sparse masks.
        for (int k = 0; k < 300; k++) begin
            logic [N-1:0] m;
            case ($urandom_range(0, 3))
                0:       m = 5'b11111;
                1:       m = 5'(1 << $urandom_range(0, N - 1));
                default: m = 5'($urandom);
            endcase
            drive(($urandom_range(0, 3) != 0), 5'($urandom), m, 5'($urandom), 5'($urandom));
        end

        // Asynchronous reset in the middle of a transaction.
        @(posedge clock);
        #1;
        bus.in_valid    = 1'b1;
        bus.unassign    = 5'b00000;
        bus.clause_mask = 5'b11111;
        bus.val         = 5'b11111;
        bus.clause_pole = 5'b00000;
        #2;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        held = '{sat: 0, conf: 0, unit: 0, idx: 0, cnt: 0};
        bus.in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        last_in_valid = 1'b0;
        mon_en        = 1'b1;

        drive(1'b1, 5'b00010, 5'b00011, 5'b00001, 5'b00001);
        drive(1'b1, 5'b00000, 5'b00011, 5'b00011, 5'b00000);
        for (int k = 0; k < 4; k++) drive(1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

        @(negedge clock);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
